// File: rtl/card_datapath.sv
// rtl/card_datapath.sv - Baccarat card datapath: card registers, deal-sequence FSM and registered scores.
module card_datapath (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] new_card,
    input  logic       load_pcard1,
    input  logic       load_pcard2,
    input  logic       load_pcard3,
    input  logic       load_dcard1,
    input  logic       load_dcard2,
    input  logic       load_dcard3,
    output logic [3:0] pcard1,
    output logic [3:0] pcard2,
    output logic [3:0] pcard3,
    output logic [3:0] dcard1,
    output logic [3:0] dcard2,
    output logic [3:0] dcard3,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic [2:0] deal_count,
    output logic       seq_error
);

    typedef enum logic [2:0] {
        S_P1, S_D1, S_P2, S_D2, S_THIRD, S_D3, S_DONE
    } state_t;

    state_t     state, state_next;
    logic [5:0] loads;
    logic [5:0] legal_mask;
    logic       one_hot;
    logic       card_ok;
    logic       accept;
    logic       violation;
    logic [4:0] psum, dsum;
    logic [3:0] pmod, dmod;

    // Bit order: player slots 1..3 then dealer slots 1..3.
    assign loads = {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1};

    function automatic logic [4:0] points(input logic [3:0] c);
        return (c >= 4'd1 && c <= 4'd9) ? {1'b0, c} : 5'd0;
    endfunction

    function automatic logic [3:0] mod10(input logic [4:0] s);
        if (s >= 5'd20)
            return 4'(s - 5'd20);
        else if (s >= 5'd10)
            return 4'(s - 5'd10);
        else
            return 4'(s);
    endfunction

    always_comb begin
        legal_mask = 6'b000000;
        state_next = state;
        case (state)
            S_P1:    legal_mask = 6'b000001;
            S_D1:    legal_mask = 6'b001000;
            S_P2:    legal_mask = 6'b000010;
            S_D2:    legal_mask = 6'b010000;
            S_THIRD: legal_mask = 6'b100100;
            S_D3:    legal_mask = 6'b100000;
            default: legal_mask = 6'b000000;
        endcase

        one_hot   = (loads != 6'd0) && ((loads & (loads - 6'd1)) == 6'd0);
        card_ok   = (new_card >= 4'd1) && (new_card <= 4'd13);
        accept    = one_hot && card_ok && ((loads & legal_mask) != 6'd0);
        violation = (loads != 6'd0) && !accept;

        if (accept) begin
            case (state)
                S_P1:    state_next = S_D1;
                S_D1:    state_next = S_P2;
                S_P2:    state_next = S_D2;
                S_D2:    state_next = S_THIRD;
                S_THIRD: state_next = load_pcard3 ? S_D3 : S_DONE;
                S_D3:    state_next = S_DONE;
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        psum = points(pcard1) + points(pcard2) + points(pcard3);
        dsum = points(dcard1) + points(dcard2) + points(dcard3);
        pmod = mod10(psum);
        dmod = mod10(dsum);
    end

    always_ff @(posedge slow_clock) begin
        if (resetb)
            state <= S_P1;
        else
            state <= state_next;
    end

    // Scores sample the card registers, so they trail a load by one extra edge.
    always_ff @(posedge slow_clock) begin
        if (resetb) begin
            pcard1     <= 4'd0;
            pcard2     <= 4'd0;
            pcard3     <= 4'd0;
            dcard1     <= 4'd0;
            dcard2     <= 4'd0;
            dcard3     <= 4'd0;
            pscore     <= 4'd0;
            dscore     <= 4'd0;
            deal_count <= 3'd0;
            seq_error  <= 1'b0;
        end else begin
            pscore <= pmod;
            dscore <= dmod;
            if (accept) begin
                if (load_pcard1) pcard1 <= new_card;
                if (load_pcard2) pcard2 <= new_card;
                if (load_pcard3) pcard3 <= new_card;
                if (load_dcard1) dcard1 <= new_card;
                if (load_dcard2) dcard2 <= new_card;
                if (load_dcard3) dcard3 <= new_card;
                if (deal_count != 3'd6)
                    deal_count <= deal_count + 3'd1;
            end
            if (violation)
                seq_error <= 1'b1;
        end
    end

endmodule

// File: doc/card_datapath.md
CARD_DATAPATH -- requirements
Module: card_datapath

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-high reset, with ports named slow_clock and resetb.
REQ-002 slow_clock  in  1  Clock; every register updates on its rising edge.
REQ-003 resetb  in  1  Reset; synchronous and active-high; clears all state on the next edge.
REQ-004 new_card  in  4  Card offered by the dealer; 1=A, 2..10, 11=J, 12=Q, 13=K; 0, 14 and 15 are invalid.
REQ-005 load_pcard1, load_pcard2, load_pcard3  in  1 each  Latch new_card into player slot 1, 2 or 3.
REQ-006 load_dcard1, load_dcard2, load_dcard3  in  1 each  Latch new_card into dealer slot 1, 2 or 3.
REQ-007 pcard1, pcard2, pcard3  out  4 each  Player card registers; 0 means empty.
REQ-008 dcard1, dcard2, dcard3  out  4 each  Dealer card registers; 0 means empty.
REQ-009 pscore, dscore  out  4 each  Registered baccarat scores, range 0..9.
REQ-010 deal_count  out  3  Number of accepted loads, range 0..6.
REQ-011 seq_error  out  1  Sticky protocol-violation flag.

Function
REQ-012 Card point value SHALL be: new_card 1..9 gives its face value; 10..13 gives 0.
REQ-013 pscore SHALL equal (sum of the points of the non-empty player slots) mod 10; dscore SHALL be computed the same way from the dealer slots.
REQ-014 Sum widths SHALL be at least 5 bits before the mod, with no truncation ahead of it (max sum 27).
REQ-015 pscore and dscore SHALL be registered.
- They reflect the card registers one edge after those registers update.
- Latency from a load edge to an updated score is 2 rising edges.
REQ-016 A load is "accepted" only if all of the following hold at the edge:
- exactly one load_* input is high;
- new_card is in 1..13;
- the load matches the legal sequence state.
REQ-017 On an accepted load:
- the addressed card register SHALL take new_card;
- deal_count SHALL increment by 1;
- the sequence FSM SHALL advance.
REQ-018 Sequence FSM states and transitions:
- S_P1 -> S_D1 on load_pcard1.
- S_D1 -> S_P2 on load_dcard1.
- S_P2 -> S_D2 on load_pcard2.
- S_D2 -> S_THIRD on load_dcard2.
- S_THIRD -> S_D3 on load_pcard3.
- S_THIRD -> S_DONE on load_dcard3.
- S_D3 -> S_DONE on load_dcard3.
REQ-019 Any of the following SHALL set seq_error on the next edge:
- a load_* input that does not match the current state;
- two or more load_* inputs high in the same cycle;
- any load while new_card is 0, 14 or 15;
- any load while in S_DONE.
REQ-020 On a violation, card registers, deal_count and FSM state SHALL remain unchanged.
REQ-021 seq_error SHALL stay at 1 until reset.
REQ-022 Accepted loads SHALL continue to be processed normally after seq_error is set.
REQ-023 deal_count SHALL saturate at 6 and SHALL never wrap.
REQ-024 When no load_* input is high, all state SHALL hold regardless of new_card.
REQ-025 The module SHALL contain no combinational path from any input to any output.

Reset
REQ-026 When resetb=1 at an edge, the following SHALL all be 0 after that edge, and the FSM SHALL be in S_P1:
- all card registers;
- pscore and dscore;
- deal_count;
- seq_error.
REQ-027 Reset SHALL take priority over any load asserted in the same cycle; that load is discarded and raises no error.
REQ-028 A reset applied mid-hand SHALL abandon the hand completely; the first post-reset accepted load SHALL be load_pcard1.

Verification
REQ-029 Legal 4-card hand:
- Stimulus: P1=7, D1=K, P2=5, D2=9, one load per cycle.
- Required: pscore=2, dscore=9 two edges after the final load; deal_count=4; seq_error=0.
REQ-030 Full 6-card hand:
- Stimulus: the REQ-029 hand, then P3=A, then D3=3.
- Required: pscore=3, dscore=2; deal_count=6; FSM in S_DONE; a further load_pcard1 sets seq_error=1 and leaves all cards unchanged.
REQ-031 Out-of-order load:
- Stimulus: load_dcard1 asserted in S_P1.
- Required: seq_error=1, dcard1=0, deal_count=0; a subsequent load_pcard1 with new_card=4 still latches pcard1=4.
REQ-032 Invalid card and simultaneous loads:
- Stimulus: load_pcard1 with new_card=14; separately, load_pcard1 and load_dcard1 together with new_card=3.
- Required: in each case no register changes and seq_error=1.
REQ-033 Mid-hand reset:
- Stimulus: after 3 accepted loads, assert resetb together with load_dcard2.
- Required: all outputs 0 on the next edge; dcard2 stays 0; load_pcard1 with new_card=Q is accepted and gives pscore=0, deal_count=1.
